// File: rtl/ysyx_25020037_pkg.sv
// ysyx_25020037_pkg: shared writeback configuration for the ysyx_25020037 core.
//   SRC_LSU / SRC_MDU : encodings carried on out_src of the writeback arbiter
//   wb_entry_w        : width of one writeback entry {we, rd, data, src}
package ysyx_25020037_pkg;

    localparam logic SRC_LSU = 1'b0;
    localparam logic SRC_MDU = 1'b1;

    function automatic int wb_entry_w(input int aw, input int dw);
        return 1 + aw + dw + 1;
    endfunction

endpackage

// File: rtl/ysyx_25020037_rr_arb2.sv
// ysyx_25020037_rr_arb2: two-way round-robin grant with a 1-bit priority pointer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req0_i, req1_i   : requests (0 = LSU, 1 = MDU)
//   en_i             : grant enable (downstream slot free)
//   gnt0_o, gnt1_o   : one-hot-or-zero grants, also acting as the transfer strobes
module ysyx_25020037_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic en_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic rr_q, rr_d, pick1;

    // rr_q = 1 means requester 1 wins a tie
    assign pick1  = req1_i & (~req0_i | rr_q);
    // rst_n gating keeps both grants low while reset is held
    assign gnt1_o = rst_n & en_i & pick1;
    assign gnt0_o = rst_n & en_i & req0_i & ~pick1;
    // a grant is a transfer because the requester's valid is already high
    assign rr_d   = gnt0_o ? 1'b1 : gnt1_o ? 1'b0 : rr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end

endmodule

// File: rtl/ysyx_25020037_wb_arb.sv
// ysyx_25020037_wb_arb: arbitrates LSU and MDU writebacks into one registered output slot.
//   clk, rst_n                              : clock, asynchronous active-low reset
//   lsu_valid/ready/we/rd/data              : LSU writeback request
//   mdu_valid/ready/we/rd/data              : mul/div writeback request
//   out_valid/ready/we/rd/data/src          : registered writeback entry to the GPR/commit stage
//   busy                                    : entry held or any request pending
module ysyx_25020037_wb_arb
    import ysyx_25020037_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic          lsu_we,
    input  logic [AW-1:0] lsu_rd,
    input  logic [DW-1:0] lsu_data,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic          mdu_we,
    input  logic [AW-1:0] mdu_rd,
    input  logic [DW-1:0] mdu_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_we,
    output logic [AW-1:0] out_rd,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    output logic          busy
);

    localparam int EW = wb_entry_w(AW, DW);

    logic          slot_free;
    logic          out_valid_q;
    logic [EW-1:0] ent_d, ent_q;

    // draining and refilling in the same cycle is allowed, so no bubble
    assign slot_free = ~out_valid_q | out_ready;

    ysyx_25020037_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0_i (lsu_valid),
        .req1_i (mdu_valid),
        .en_i   (slot_free),
        .gnt0_o (lsu_ready),
        .gnt1_o (mdu_ready)
    );

    // writes to x0 still commit, just without a register write
    always_comb begin
        ent_d = mdu_ready ? {mdu_we & (|mdu_rd), mdu_rd, mdu_data, SRC_MDU}
                          : {lsu_we & (|lsu_rd), lsu_rd, lsu_data, SRC_LSU};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ent_q       <= '0;
        end else if (lsu_ready | mdu_ready) begin
            out_valid_q <= 1'b1;
            ent_q       <= ent_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_we, out_rd, out_data, out_src} = ent_q;
    assign busy = out_valid_q | lsu_valid | mdu_valid;

endmodule

// File: tb/tb_ysyx_25020037_wb_arb.sv
// tb_ysyx_25020037_wb_arb: directed self-checking bench with a reference model and scoreboard.
module tb_ysyx_25020037_wb_arb;

    logic        clk, rst_n;
    logic        lsu_valid, lsu_ready, lsu_we;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        mdu_valid, mdu_ready, mdu_we;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        out_valid, out_ready, out_we, out_src, busy;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    ysyx_25020037_wb_arb dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_we(mdu_we), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .out_src(out_src), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [38:0] sb[$];
    logic m_rr, m_ov;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one cycle: drive, check readies against the model, clock, check the output slot
    task automatic step(input logic lv, input logic mv, input logic ord);
        logic free, gl, gm;
        lsu_valid = lv;
        mdu_valid = mv;
        out_ready = ord;
        #1;
        free = ~m_ov | ord;
        gm = free & mv & (~lv | m_rr);
        gl = free & lv & ~gm;
        chk("lsu_ready", 64'(lsu_ready), 64'(gl));
        chk("mdu_ready", 64'(mdu_ready), 64'(gm));
        chk("busy", 64'(busy), 64'(m_ov | lv | mv));
        if (m_ov && ord) void'(sb.pop_front());
        if (gl) begin
            sb.push_back({lsu_we & (lsu_rd != 0), lsu_rd, lsu_data, 1'b0});
            m_rr = 1'b1;
        end
        if (gm) begin
            sb.push_back({mdu_we & (mdu_rd != 0), mdu_rd, mdu_data, 1'b1});
            m_rr = 1'b0;
        end
        m_ov = gl | gm | (m_ov & ~ord);
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            if (sb.size() == 0) chk("scoreboard_empty", 64'(sb.size()), 64'd1);
            else chk("out_entry", 64'({out_we, out_rd, out_data, out_src}), 64'(sb[0]));
        end
    endtask

    task automatic model_reset();
        m_rr = 1'b0;
        m_ov = 1'b0;
        sb.delete();
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        lsu_valid = 1'b1; lsu_we = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
        mdu_valid = 1'b1; mdu_we = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h22;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("rst_mdu_ready", 64'(mdu_ready), 64'd0);
        chk("rst_out_fields", 64'({out_we, out_rd, out_data, out_src}), 64'd0);
        rst_n = 1'b1;

        // contention: LSU first after reset, then strict alternation
        repeat (4) step(1, 1, 1);
        chk("alt_last_src", 64'(out_src), 64'd1);

        // backpressure: held entry must stay stable with both readies low
        step(1, 1, 0);
        repeat (3) step(1, 1, 0);
        step(1, 1, 1);
        step(0, 0, 1);

        // x0 write keeps data and source, suppresses the write
        lsu_rd = 5'd0; lsu_data = 32'hDEADBEEF;
        step(1, 0, 1);
        chk("x0_we", 64'(out_we), 64'd0);
        chk("x0_data", 64'(out_data), 64'hDEADBEEF);
        chk("x0_src", 64'(out_src), 64'd0);

        // non-writing MDU request, then MDU alone for four cycles
        mdu_we = 1'b0; mdu_rd = 5'd7; mdu_data = 32'h5A5A;
        step(0, 1, 1);
        chk("nowe_we", 64'(out_we), 64'd0);
        mdu_we = 1'b1; mdu_rd = 5'd9;
        repeat (4) begin
            mdu_data = mdu_data + 32'd1;
            step(0, 1, 1);
        end
        // rr must be back at LSU-first
        lsu_rd = 5'd1; lsu_data = 32'hCAFE;
        step(1, 1, 1);
        chk("rr_after_mdu_src", 64'(out_src), 64'd0);
        step(0, 0, 1);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // reset while an entry is stalled
        step(0, 1, 0);
        step(0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_mdu_ready", 64'(mdu_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
